xs3_word_converter: RTL and testbench

//  Multi-digit, bidirectional BCD <-> excess-3 code converter with valid/ready handshakes.

---
 rtl/xs3_word_converter.sv | 148 ++++++++++++++
 tb/tb_xs3_word_converter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/xs3_word_converter.sv
// Multi-digit BCD <-> excess-3 word converter: one nibble per clock, LSD first, valid/ready on both sides.
// Optional range checking is enabled by defining ERR_DETECT_EN.
module xs3_word_converter #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_mode,
  input  logic [4*DIGITS-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_data,
  output logic                  out_err
);

  localparam int CW = $clog2(DIGITS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_r, state_next;
  logic                mode_r, mode_next;
  logic [CW-1:0]       cnt_r, cnt_next;
  logic [4*DIGITS-1:0] data_next;
  logic                valid_next, ready_next, err_next;
  logic [3:0]          cur_digit_s;
  logic [4:0]          conv_s;

  // Returns {invalid, result}; invalid is only ever raised when range checking is built in.
  function automatic logic [4:0] conv_digit(input logic [3:0] d, input logic mode);
    logic [3:0] res;
    logic       bad;
    if (mode == 1'b0) begin
      res = d + 4'd3;
      bad = (d > 4'd9);
    end else begin
      res = d - 4'd3;
      bad = (d < 4'd3) || (d > 4'd12);
    end
`ifdef ERR_DETECT_EN
    if (bad) begin
      res = 4'hF;
    end else begin
      res = res;
    end
`else
    bad = 1'b0;
`endif
    return {bad, res};
  endfunction

  // Select the digit addressed by the counter and convert it.
  always_comb begin
    cur_digit_s = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (cnt_r == CW'(i)) begin
        cur_digit_s = out_data[4*i +: 4];
      end else begin
        cur_digit_s = cur_digit_s;
      end
    end
    conv_s = conv_digit(cur_digit_s, mode_r);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_next = state_r;
    data_next  = out_data;
    mode_next  = mode_r;
    cnt_next   = cnt_r;
    valid_next = out_valid;
    ready_next = in_ready;
    err_next   = out_err;
    case (state_r)
      IDLE: begin
        if (in_valid && in_ready) begin
          data_next  = in_data;
          mode_next  = in_mode;
          err_next   = 1'b0;
          cnt_next   = '0;
          ready_next = 1'b0;
          state_next = CONV;
        end else begin
          ready_next = 1'b1;
        end
      end
      CONV: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (cnt_r == CW'(i)) begin
            data_next[4*i +: 4] = conv_s[3:0];
          end else begin
            data_next[4*i +: 4] = out_data[4*i +: 4];
          end
        end
        err_next = out_err | conv_s[4];
        // Last digit written on this edge: result becomes visible next cycle.
        if (cnt_r == CW'(DIGITS - 1)) begin
          cnt_next   = '0;
          valid_next = 1'b1;
          state_next = DONE;
        end else begin
          cnt_next = cnt_r + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          valid_next = 1'b0;
          ready_next = 1'b1;
          state_next = IDLE;
        end else begin
          valid_next = 1'b1;
        end
      end
      default: begin
        valid_next = 1'b0;
        ready_next = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      mode_r    <= 1'b0;
      cnt_r     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else begin
      state_r   <= state_next;
      mode_r    <= mode_next;
      cnt_r     <= cnt_next;
      in_ready  <= ready_next;
      out_valid <= valid_next;
      out_data  <= data_next;
      out_err   <= err_next;
    end
  end

endmodule

// File: tb/tb_xs3_word_converter.sv
// Directed self-checking bench for xs3_word_converter (DIGITS=4); expectations follow ERR_DETECT_EN.
module tb_xs3_word_converter;

  localparam int DIGITS = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic                in_mode = 1'b0;
  logic [4*DIGITS-1:0] in_data = 16'h0000;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [4*DIGITS-1:0] out_data;
  logic                out_err;

  int checks = 0;
  int fails  = 0;

  xs3_word_converter #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
  );

  always #5 clk = ~clk;

  // Present a word, then scramble mode/data after acceptance; returns edges until out_valid.
  task automatic run_word(input logic mode, input logic [15:0] data,
                          output logic [15:0] got, output logic got_err, output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    in_valid = 1'b1;
    in_mode  = mode;
    in_data  = data;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_mode  = ~mode;
    in_data  = ~data;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid && lat < 20);
    got     = out_data;
    got_err = out_err;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 16'h0000) begin fails++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
    checks++; if (out_err !== 1'b0) begin fails++; $display("FAIL reset_out_err got=%b exp=0", out_err); end
  endtask

  task automatic test_convert();
    logic        modes [6];
    logic [15:0] ins   [6];
    logic [15:0] exps  [6];
    logic        errs  [6];
    logic [15:0] got;
    logic        ge;
    int          lat;
    modes = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    ins   = '{16'h1234, 16'h4567, 16'h9999, 16'h3333, 16'h9A00, 16'h2D34};
`ifdef ERR_DETECT_EN
    exps  = '{16'h4567, 16'h1234, 16'hCCCC, 16'h0000, 16'hCF33, 16'hFF01};
    errs  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`else
    exps  = '{16'h4567, 16'h1234, 16'hCCCC, 16'h0000, 16'hCD33, 16'hFA01};
    errs  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    for (int i = 0; i < 6; i++) begin
      run_word(modes[i], ins[i], got, ge, lat);
      checks++; if (lat !== DIGITS) begin fails++; $display("FAIL conv_latency[%0d] got=%0d exp=%0d", i, lat, DIGITS); end
      checks++; if (got !== exps[i]) begin fails++; $display("FAIL conv_data[%0d] in=%h got=%h exp=%h", i, ins[i], got, exps[i]); end
      checks++; if (ge !== errs[i]) begin fails++; $display("FAIL conv_err[%0d] got=%b exp=%b", i, ge, errs[i]); end
      release_out();
    end
  endtask

  task automatic test_stall();
    logic [15:0] got;
    logic        ge;
    int          lat;
    run_word(1'b0, 16'h0505, got, ge, lat);
    checks++; if (got !== 16'h3838) begin fails++; $display("FAIL stall_data got=%h exp=3838", got); end
    in_valid = 1'b1;
    in_data  = 16'h7777;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_data !== 16'h3838 || in_ready !== 1'b0) begin
        fails++; $display("FAIL stall_hold[%0d] got valid=%b data=%h in_ready=%b exp 1/3838/0", c, out_valid, out_data, in_ready);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL stall_release got valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] got;
    logic        ge;
    int          lat;
    @(negedge clk);
    in_valid = 1'b1;
    in_mode  = 1'b0;
    in_data  = 16'h1234;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 16'h0000) begin
      fails++; $display("FAIL midreset_state got in_ready=%b valid=%b data=%h exp 1/0/0000", in_ready, out_valid, out_data);
    end
    repeat (6) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midreset_no_stale got=%b exp=0", out_valid); end
    run_word(1'b0, 16'h0000, got, ge, lat);
    checks++; if (got !== 16'h3333 || lat !== DIGITS) begin
      fails++; $display("FAIL midreset_new got=%h lat=%0d exp=3333 lat=%0d", got, lat, DIGITS);
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    logic [15:0] words [3];
    logic [15:0] exps  [3];
    int          acc   [3];
    int          idx, oidx, cyc;
    words = '{16'h0123, 16'h4567, 16'h8901};
    exps  = '{16'h3456, 16'h789A, 16'hBC34};
    idx = 0; oidx = 0; cyc = 0;
    out_ready = 1'b1;
    while (cyc < 60 && oidx < 3) begin
      @(negedge clk);
      if (out_valid) begin
        checks++; if (out_data !== exps[oidx]) begin
          fails++; $display("FAIL b2b_data[%0d] got=%h exp=%h", oidx, out_data, exps[oidx]);
        end
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL b2b_overlap[%0d] got in_ready=%b exp=0", oidx, in_ready); end
        oidx++;
      end
      if (idx < 3) begin
        in_valid = 1'b1;
        in_mode  = 1'b0;
        in_data  = words[idx];
        if (in_ready) begin
          acc[idx] = cyc;
          idx++;
        end
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++; if (oidx !== 3) begin fails++; $display("FAIL b2b_count got=%0d exp=3", oidx); end
    if (idx == 3) begin
      checks++; if (acc[1] - acc[0] !== DIGITS + 2) begin fails++; $display("FAIL b2b_period0 got=%0d exp=%0d", acc[1] - acc[0], DIGITS + 2); end
      checks++; if (acc[2] - acc[1] !== DIGITS + 2) begin fails++; $display("FAIL b2b_period1 got=%0d exp=%0d", acc[2] - acc[1], DIGITS + 2); end
    end else begin
      checks++; fails++; $display("FAIL b2b_accepts got=%0d exp=3", idx);
    end
  endtask

  initial begin
    test_reset();
    test_convert();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
